// File: rtl/sevenseg_scan_mux_pkg.sv
// Shared seven-segment encodings and timing helpers for the scanned display.
// Glyphs are active-low {g,f,e,d,c,b,a} for a common-anode display.
package sevenseg_scan_mux_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_GLYPH [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic int slot_cycles(input int clk_hz, input int frame_hz, input int num_digits);
    return clk_hz / (frame_hz * num_digits);
  endfunction

  function automatic int blink_half(input int clk_hz, input int blink_hz);
    return clk_hz / (2 * blink_hz);
  endfunction

endpackage

// File: rtl/sevenseg_scan_mux_seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes A-E are blank and F is a dash so the alarm-set display can reuse it.
module seg7_decode
  import sevenseg_scan_mux_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_GLYPH[0];
      4'd1:    o_seg = SEG_GLYPH[1];
      4'd2:    o_seg = SEG_GLYPH[2];
      4'd3:    o_seg = SEG_GLYPH[3];
      4'd4:    o_seg = SEG_GLYPH[4];
      4'd5:    o_seg = SEG_GLYPH[5];
      4'd6:    o_seg = SEG_GLYPH[6];
      4'd7:    o_seg = SEG_GLYPH[7];
      4'd8:    o_seg = SEG_GLYPH[8];
      4'd9:    o_seg = SEG_GLYPH[9];
      4'hF:    o_seg = SEG_DASH;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver with per-frame snapshot,
// anti-ghost blanking at the start of each slot, per-digit enable, DP and blink.
module sevenseg_scan_mux
  import sevenseg_scan_mux_pkg::*;
#(
  parameter int CLK_HZ       = 100000000,
  parameter int FRAME_HZ     = 1000,
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_HZ     = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int SLOT_CYCLES = slot_cycles(CLK_HZ, FRAME_HZ, NUM_DIGITS);
  localparam int BLINK_HALF  = blink_half(CLK_HZ, BLINK_HZ);
  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("NUM_DIGITS must be in 2..8");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad_blank
    $error("BLANK_CYCLES must be less than SLOT_CYCLES");
  end
  if (BLINK_HALF < 1) begin : g_bad_blink
    $error("blink half-period must be at least one cycle");
  end

  logic [SW-1:0]           r_slot_cnt;
  logic [IW-1:0]           r_idx;
  logic [BW-1:0]           r_blink_cnt;
  logic                    r_blink_phase;
  logic [4*NUM_DIGITS-1:0] r_snap_digits;
  logic [NUM_DIGITS-1:0]   r_snap_en;
  logic [NUM_DIGITS-1:0]   r_snap_dp;
  logic [NUM_DIGITS-1:0]   r_snap_blink;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_start;

  logic                    w_frame_tick;
  logic                    w_slot_wrap;
  logic                    w_in_blank;
  logic                    w_lit;
  logic [4*NUM_DIGITS-1:0] w_cur_digits;
  logic [NUM_DIGITS-1:0]   w_cur_en;
  logic [NUM_DIGITS-1:0]   w_cur_dp;
  logic [NUM_DIGITS-1:0]   w_cur_blink;
  logic [NUM_DIGITS-1:0]   w_an_onehot;
  logic [3:0]              w_bcd;
  logic [6:0]              w_glyph;

  assign w_frame_tick = (r_idx == '0) && (r_slot_cnt == '0);
  assign w_slot_wrap  = (r_slot_cnt == SLOT_LAST);
  assign w_in_blank   = (r_slot_cnt < BLANK_END);

  // On the snapshot cycle itself the register still holds the old frame, so use the values being captured.
  assign w_cur_digits = w_frame_tick ? digits     : r_snap_digits;
  assign w_cur_en     = w_frame_tick ? digit_en   : r_snap_en;
  assign w_cur_dp     = w_frame_tick ? dp_mask    : r_snap_dp;
  assign w_cur_blink  = w_frame_tick ? blink_mask : r_snap_blink;

  assign w_bcd       = w_cur_digits[{r_idx, 2'b00} +: 4];
  assign w_lit       = w_cur_en[r_idx] && !(w_cur_blink[r_idx] && !r_blink_phase);
  assign w_an_onehot = ~(NUM_DIGITS'(1) << r_idx);

  seg7_decode u_decode (
    .i_bcd (w_bcd),
    .o_seg (w_glyph)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_cnt <= '0;
      r_idx      <= '0;
    end else if (w_slot_wrap) begin
      r_slot_cnt <= '0;
      r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap_digits <= '0;
      r_snap_en     <= '0;
      r_snap_dp     <= '0;
      r_snap_blink  <= '0;
    end else if (w_frame_tick) begin
      r_snap_digits <= digits;
      r_snap_en     <= digit_en;
      r_snap_dp     <= dp_mask;
      r_snap_blink  <= blink_mask;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an          <= '1;
      r_seg         <= SEG_BLANK;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_tick;
      if (!w_in_blank && w_lit) begin
        r_an  <= w_an_onehot;
        r_seg <= w_glyph;
        r_dp  <= ~w_cur_dp[r_idx];
      end else begin
        r_an  <= '1;
        r_seg <= SEG_BLANK;
        r_dp  <= 1'b1;
      end
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule
